mem_burst_device: RTL and testbench
===================================

# mem_burst_device

Parametrised, synthesizable memory device for the device side of the memory interface. It serves multi-beat read and write bursts with programmable access latency, byte-enable writes and optional critical-word-first wrap ordering. It raises an error flag for out-of-range and illegal requests. It replaces the fixed single-beat memory model behind the cache under test and is the backing store for cache fill/evict bursts.

## Interface
- DATA_W, 32, beat width in bits; multiple of 8
- DEPTH, 1024, storage depth in DATA_W-bit words; power of 2
- BURST_BEATS, 4, beats per transaction; power of 2, ≤ DEPTH
- LATENCY, 2, idle cycles between request sample and first beat; ≥ 1
- WRAP, 0, 0 = bursts start at burst-aligned word; 1 = critical-word-first, wrapping within aligned block
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  read request; held by controller until last beat's mem_resp
- mem_write  input  1  write request; same hold rule
- mem_address  input  32  byte address; sampled only when request is accepted
- mem_wdata  input  DATA_W  write data for current beat
- mem_byte_enable  input  DATA_W/8  per-byte write enable for current beat
- mem_resp  output  1  beat handshake; one pulse per beat
- mem_rdata  output  DATA_W  read data; valid only while mem_resp = 1, else 0
- mem_error  output  1  asserted alongside every mem_resp of a failed transaction

## Operation
- Word index = mem_address >> log2(DATA_W/8); low byte-offset bits ignored.
- Start word S = word index mod BURST_BEATS. Block base B = word index with low log2(BURST_BEATS) bits cleared.
- Beat k (0..BURST_BEATS-1) targets word B + k (WRAP=0) or B + ((S + k) mod BURST_BEATS) (WRAP=1).
- Out of range: any word index ≥ DEPTH, i.e. address bits above the index field nonzero. All beats of that transaction give mem_error=1 and mem_rdata=0, and no writes occur.
- Illegal: mem_read and mem_write both 1 at acceptance. Treated as out of range (full-length burst, error on every beat, no write).
- Write beat k: on each cycle with mem_resp=1, store mem_wdata into the target word for bytes whose mem_byte_enable bit is 1. Other bytes are unchanged.
- Read beat k: mem_rdata is the target word's content as of that cycle. Read-after-write to the same word across transactions returns the new data.
- Address, opcode and error status are latched at acceptance. Input changes mid-burst are ignored, except mem_wdata and mem_byte_enable, which are sampled per beat.
- FSM states:
  - IDLE: accept when mem_read|mem_write; go to WAIT with latency counter = LATENCY-1.
  - WAIT: count down; at 0 go to BURST with beat counter = 0.
  - BURST: mem_resp=1 every cycle; beat counter increments; after beat BURST_BEATS-1 go to DONE.
  - DONE: one cycle, request inputs ignored, then go to IDLE.
- Storage contents are not cleared by rst.

## Timing
- Reset: on the edge with rst=1, state→IDLE, counters→0, and mem_resp, mem_rdata, mem_error→0 from the next cycle.
- rst mid-burst aborts the transaction. Remaining beats are not issued. Writes already performed persist.
- All outputs are registered.
- Request sampled in cycle 0 (IDLE) → mem_resp=1 in cycles LATENCY+1 .. LATENCY+BURST_BEATS, contiguous, no gaps.
- Cycle LATENCY+BURST_BEATS+1 is DONE. The controller must drop the request by then.
- A request seen in cycle LATENCY+BURST_BEATS+2 (IDLE) starts a new transaction. Back-to-back throughput is one burst per LATENCY+BURST_BEATS+2 cycles.
- Controller updates mem_wdata/mem_byte_enable for beat k+1 in the cycle after mem_resp for beat k. The device samples the beat's data at the edge ending its mem_resp cycle.

## Test plan
- Reset: hold rst 3 cycles mid-burst → mem_resp/mem_rdata/mem_error = 0 the cycle after reset; no further beats; words written before reset read back intact.
- Aligned write then read, defaults: write 0x11111111..0x44444444 to address 0x100 (all BE=1); read 0x100 → resp in cycles 3–6 carrying 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- Wrap, WRAP=1: same data, read address 0x108 → beats 0x33333333, 0x44444444, 0x11111111, 0x22222222. With WRAP=0 → beats 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- Byte enables: word holds 0xAABBCCDD; write 0x11223344 with BE=4'b0101 → read returns 0xAA22CC44.
- Errors:
  - Read at address 0x1000 (word 1024, DEPTH=1024) → 4 beats, mem_error=1, mem_rdata=0.
  - Read and write both high at acceptance → 4 error beats; memory unchanged.
- Latency sweep: LATENCY=1 and LATENCY=5 → first resp at cycle 2 and 6 respectively. A request held through DONE is re-accepted at cycle LATENCY+BURST_BEATS+2.

Source files
------------

// File: rtl/mem_burst_if.sv
// Memory bus between a burst controller (master) and the memory device (slave).
interface mem_burst_if #(
    parameter int DATA_W = 32
) ();
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_address;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_byte_enable;
    logic                  mem_resp;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_error;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata, mem_error
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata, mem_error
    );
endinterface

// File: rtl/mem_burst_device.sv
// Burst memory device: fixed-length read/write bursts after a programmable
// access latency, byte-enable writes, optional critical-word-first wrapping,
// and an error flag for out-of-range or read+write requests.
module mem_burst_device #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int BURST_BEATS = 4,
    parameter int LATENCY     = 2,
    parameter int WRAP        = 0
) (
    input  logic        clk,
    input  logic        rst,
    mem_burst_if.slave  bus
);
    localparam int NBYTES  = DATA_W / 8;
    localparam int IDX_LSB = $clog2(NBYTES);
    localparam int AW      = $clog2(DEPTH);
    localparam int BCW     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int LCW     = $clog2(LATENCY + 1);

    localparam logic [AW-1:0]  OFF_MASK  = AW'(BURST_BEATS - 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_BEATS - 1);
    localparam logic [LCW-1:0] LAT_INIT  = LCW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [LCW-1:0]      lat_q;
    logic [BCW-1:0]      beat_q;
    logic [AW-1:0]       base_q;
    logic [AW-1:0]       start_q;
    logic                is_wr_q;
    logic                bad_q;
    logic                resp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [AW-1:0]       idx_s;
    logic                oor_s;
    logic                we_s;
    logic [AW-1:0]       wr_word_s;
    logic [BCW-1:0]      next_beat_s;

    // Word targeted by beat k: block base plus an offset that optionally
    // starts at the critical word and wraps inside the aligned block.
    function automatic logic [AW-1:0] beat_word(input logic [AW-1:0]  base,
                                                input logic [AW-1:0]  start,
                                                input logic [BCW-1:0] k);
        logic [AW-1:0] off;
        off = (WRAP != 0) ? (start + AW'(k)) : AW'(k);
        return base | (off & OFF_MASK);
    endfunction

    assign idx_s       = bus.mem_address[IDX_LSB +: AW];
    assign oor_s       = ((bus.mem_address >> (IDX_LSB + AW)) != 32'd0);
    assign next_beat_s = beat_q + BCW'(1);

    // Write strobe for the current beat; suppressed on error and during reset.
    always_comb begin
        we_s      = 1'b0;
        wr_word_s = beat_word(base_q, start_q, beat_q);
        if ((state_q == ST_BURST) && is_wr_q && !bad_q && !rst) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Storage: byte-masked write at the edge ending each write beat; never reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.mem_byte_enable[b]) begin
                    mem_q[wr_word_s][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake, data and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            base_q  <= '0;
            start_q <= '0;
            is_wr_q <= 1'b0;
            bad_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (bus.mem_read || bus.mem_write) begin
                        base_q  <= idx_s & ~OFF_MASK;
                        start_q <= idx_s & OFF_MASK;
                        is_wr_q <= bus.mem_write & ~bus.mem_read;
                        bad_q   <= oor_s | (bus.mem_read & bus.mem_write);
                        lat_q   <= LAT_INIT;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= ST_BURST;
                        beat_q  <= '0;
                        resp_q  <= 1'b1;
                        err_q   <= bad_q;
                        rdata_q <= (bad_q || is_wr_q) ? '0
                                 : mem_q[beat_word(base_q, start_q, '0)];
                    end else begin
                        lat_q <= lat_q - LCW'(1);
                    end
                end
                ST_BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q <= ST_DONE;
                        resp_q  <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        beat_q  <= next_beat_s;
                        resp_q  <= 1'b1;
                        err_q   <= bad_q;
                        rdata_q <= (bad_q || is_wr_q) ? '0
                                 : mem_q[beat_word(base_q, start_q, next_beat_s)];
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.mem_error = err_q;
endmodule

// File: tb/tb_mem_burst_device.sv
// Directed bench: three device instances (defaults, WRAP=1/LATENCY=5,
// LATENCY=1) sharing address/data lines, each with its own request lines.
module tb_mem_burst_device;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rd_v = 3'b000;
    logic [2:0]  wr_v = 3'b000;
    logic [31:0] addr_v = 32'd0;
    logic [31:0] wdata_v = 32'd0;
    logic [3:0]  be_v = 4'h0;
    logic [2:0]  resp_v;
    logic [2:0]  err_v;
    logic [31:0] rdata_v [3];

    localparam int LATS  [3] = '{2, 5, 1};
    localparam int WRAPS [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mem_burst_if #(.DATA_W(32)) bus ();
        assign bus.mem_read        = rd_v[g];
        assign bus.mem_write       = wr_v[g];
        assign bus.mem_address     = addr_v;
        assign bus.mem_wdata       = wdata_v;
        assign bus.mem_byte_enable = be_v;
        assign resp_v[g]           = bus.mem_resp;
        assign err_v[g]            = bus.mem_error;
        assign rdata_v[g]          = bus.mem_rdata;
        mem_burst_device #(
            .DATA_W(32), .DEPTH(1024), .BURST_BEATS(4),
            .LATENCY(LATS[g]), .WRAP(WRAPS[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] wbeat  [4];
    logic [3:0]  bebeat [4];
    logic [31:0] got_d  [4];
    logic        got_e  [4];
    int          nbeats;
    int          first_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [3:0] b0, input logic [3:0] brest);
        wbeat[0] = d0; wbeat[1] = d1; wbeat[2] = d2; wbeat[3] = d3;
        bebeat[0] = b0; bebeat[1] = brest; bebeat[2] = brest; bebeat[3] = brest;
    endtask

    // Issue one request on device d from the current IDLE cycle (cycle 0)
    // and collect the beats; returns at #1 into the IDLE cycle after DONE.
    task automatic burst(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic hold);
        int   cyc;
        logic done;
        nbeats = 0; first_c = -1; done = 1'b0; cyc = 0;
        for (int i = 0; i < 4; i++) begin got_d[i] = 32'hx; got_e[i] = 1'bx; end
        @(negedge clk);
        rd_v[d] = r; wr_v[d] = w; addr_v = a;
        wdata_v = wbeat[0]; be_v = bebeat[0];
        @(posedge clk);
        while (!done && cyc < 40) begin
            #1; cyc++;
            if (nbeats < 4) begin wdata_v = wbeat[nbeats]; be_v = bebeat[nbeats]; end
            if (resp_v[d]) begin
                if (nbeats < 4) begin got_d[nbeats] = rdata_v[d]; got_e[nbeats] = err_v[d]; end
                if (nbeats == 0) first_c = cyc;
                nbeats++;
            end else if (nbeats > 0) begin
                done = 1'b1;
            end
            if (!done) @(posedge clk);
        end
        if (!hold) begin rd_v[d] = 1'b0; wr_v[d] = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic chk_burst(input string tag, input int first_exp,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input logic e, input logic chk_data);
        logic [31:0] exp_d [4];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        chk({tag, "_beats"}, nbeats, 32'd4);
        chk({tag, "_first"}, first_c, first_exp);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_err%0d", tag, i), {31'd0, got_e[i]}, {31'd0, e});
            if (chk_data) chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        end
    endtask

    initial begin
        logic anyresp;
        set_wr(32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp",  {31'd0, resp_v[0]}, 32'd0);
        chk("rst_rdata", rdata_v[0], 32'd0);
        chk("rst_err",   {31'd0, err_v[0]}, 32'd0);
        rst = 1'b0;

        // Default device: aligned write, aligned read, unaligned read without wrap
        set_wr(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'hF, 4'hF);
        burst(0, 1'b0, 1'b1, 32'h100, 1'b0);
        chk_burst("wr100", 3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        burst(0, 1'b1, 1'b0, 32'h100, 1'b0);
        chk_burst("rd100", 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);
        burst(0, 1'b1, 1'b0, 32'h108, 1'b0);
        chk_burst("rd108_nowrap", 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);

        // Byte enables: only bytes 0 and 2 of word 0 updated, rest of block untouched
        set_wr(32'hAABBCCDD, 32'h55555555, 32'h66666666, 32'h77777777, 4'hF, 4'hF);
        burst(0, 1'b0, 1'b1, 32'h300, 1'b0);
        set_wr(32'h11223344, 32'h99999999, 32'h99999999, 32'h99999999, 4'b0101, 4'b0000);
        burst(0, 1'b0, 1'b1, 32'h300, 1'b0);
        burst(0, 1'b1, 1'b0, 32'h300, 1'b0);
        chk_burst("rd300_be", 3, 32'hAA22CC44, 32'h55555555, 32'h66666666, 32'h77777777, 1'b0, 1'b1);

        // Out-of-range read and illegal read+write
        burst(0, 1'b1, 1'b0, 32'h1000, 1'b0);
        chk_burst("oor", 3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        set_wr(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 4'hF);
        burst(0, 1'b1, 1'b1, 32'h100, 1'b0);
        chk_burst("illegal", 3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        burst(0, 1'b1, 1'b0, 32'h100, 1'b0);
        chk_burst("rd100_after_illegal", 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);

        // Reset held 3 cycles in the middle of a read burst
        @(negedge clk);
        rd_v[0] = 1'b1; addr_v = 32'h100;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_inburst", {31'd0, resp_v[0]}, 32'd1);
        rst = 1'b1; rd_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_resp",  {31'd0, resp_v[0]}, 32'd0);
        chk("rst_mid_rdata", rdata_v[0], 32'd0);
        chk("rst_mid_err",   {31'd0, err_v[0]}, 32'd0);
        rst = 1'b0;
        anyresp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            anyresp = anyresp | resp_v[0];
        end
        chk("rst_no_more_beats", {31'd0, anyresp}, 32'd0);
        burst(0, 1'b1, 1'b0, 32'h100, 1'b0);
        chk_burst("rd100_after_rst", 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);

        // Request held through DONE is taken as a new request in the next IDLE cycle
        burst(0, 1'b1, 1'b0, 32'h104, 1'b1);
        chk_burst("hold_a", 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);
        burst(0, 1'b1, 1'b0, 32'h104, 1'b0);
        chk_burst("hold_b", 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);

        // WRAP=1, LATENCY=5 device: critical word first
        set_wr(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'hF, 4'hF);
        burst(1, 1'b0, 1'b1, 32'h100, 1'b0);
        chk_burst("l5_wr", 6, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        burst(1, 1'b1, 1'b0, 32'h108, 1'b0);
        chk_burst("l5_wrap108", 6, 32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222, 1'b0, 1'b1);

        // LATENCY=1 device
        burst(2, 1'b0, 1'b1, 32'h100, 1'b0);
        chk_burst("l1_wr", 2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        burst(2, 1'b1, 1'b0, 32'h100, 1'b0);
        chk_burst("l1_rd", 2, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
